dds_quadrant_ctrl: RTL and testbench
====================================

DDS_QUADRANT_CTRL -- requirements
Module: dds_quadrant_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 en  in  1  advance phase accumulator this cycle.
REQ-005 phase_clr  in  1  synchronous phase clear; priority over en.
REQ-006 ftw  in  32  frequency tuning word.
REQ-007 ftw_valid  in  1  ftw offered.
REQ-008 ftw_ready  out  1  ftw acceptable; transfer when ftw_valid&&ftw_ready.
REQ-009 lut_addr  out  10  quarter-wave table address; combinational from phase registers; the table registers it.
REQ-010 lut_data  in  23  unsigned quarter-wave magnitude, valid one cycle after lut_addr.
REQ-011 sin_out  out  24  signed two's-complement full-wave sample, registered.
REQ-012 sin_valid  out  1  sin_out updated this cycle.

Function
REQ-013 SHALL hold phase_q[31:0]; on en=1, phase_q <= phase_q + ftw_active (mod 2^32); on en=0, phase_q holds.
REQ-014 On phase_clr=1, SHALL set phase_q <= 0 regardless of en.
REQ-015 Accepted ftw SHALL go to pending register; ftw_ready=0 while pending is full.
REQ-016 Pending SHALL move to ftw_active on the first en cycle whose addition carries out of bit 31, or on any en cycle if ftw_active==0, or on phase_clr; that cycle's addition uses the old ftw_active.
REQ-017 ftw_ready SHALL return to 1 the cycle after pending is applied; no accept occurs in the apply cycle.
REQ-018 Quadrant q=phase_m[31:30], idx=phase_m[29:20], phase_m being the mapping phase (REQ-028/029).
REQ-019 lut_addr SHALL be idx for q=0,2 and 1023-idx for q=1,3.
REQ-020 q SHALL be delayed one register to align with lut_data.
REQ-021 sin_out SHALL be +{0,lut_data} for q=0,1 and -{0,lut_data} for q=2,3 (negated zero = 0).
REQ-022 Latency: en sampled at edge k -> sin_out/sin_valid update at edge k+2; sin_valid is en delayed by 3 register stages.
REQ-023 When sin_valid=0, sin_out SHALL hold its last value.

Reset
REQ-024 rst_n low SHALL immediately clear phase_q, ftw_active, pending, the q delay, and valid pipeline to 0.
REQ-025 Under reset: sin_out=0, sin_valid=0, ftw_ready=1, lut_addr=0.
REQ-026 Reset mid-operation SHALL discard pending ftw and in-flight samples; no sin_valid pulse within 3 cycles after release.

Configuration
REQ-027 Macro DDS_PHASE_DITHER_EN SHALL select phase dithering.
REQ-028 With DDS_PHASE_DITHER_EN: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances on en, reseeds on reset/phase_clr; phase_m = phase_q + {12'h0,lfsr,4'h0}; not fed back into phase_q.
REQ-029 Without DDS_PHASE_DITHER_EN: phase_m = phase_q; no LFSR logic present.

Structure
REQ-030 Package dds_pkg SHALL hold PHASE_W=32, ADDR_W=10, LUT_W=23, OUT_W=24, quadrant enum (Q0..Q3), LFSR seed and tap constants.
REQ-031 Sub-module dds_phase_acc SHALL contain phase_q, ftw_active, pending register and ftw handshake; mapping, alignment and sign stage stay in the top.

Verification (bench models a 1-cycle registered quarter-wave table; entry 0=0, entry 1023=23'h7ffff6)
REQ-032 Reset: hold rst_n=0 -> sin_out=0, sin_valid=0, ftw_ready=1, lut_addr=0; release, en=0 -> outputs stay.
REQ-033 ftw=32'h4000_0000 accepted, en=1 continuous -> lut_addr 1023,0,1023,0,...; sin_out +24'h7ffff6, 0, 24'h80000A, 0 repeating, each 2 cycles after its address.
REQ-034 ftw=32'h0010_0000 -> lut_addr 0..1023 ascending in Q0, 1023..0 descending in Q1, sign negative in Q2/Q3; period 4096 cycles.
REQ-035 Second ftw offered while pending -> ftw_ready=0, not accepted; new word takes effect only on cycle after carry-out; phase continuous across change.
REQ-036 en dropped for 5 cycles mid-stream -> phase_q holds, sin_valid low for 5 cycles starting 3 cycles later, sin_out holds; phase_clr mid-stream -> next lut_addr=0.
REQ-037 rst_n pulsed low mid-stream with pending ftw -> outputs cleared asynchronously, ftw_ready=1, pending discarded.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared widths, quadrant type and dither LFSR constants for the DDS core.
// LFSR constants are used only when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 10;
  localparam int LUT_W   = 23;
  localparam int OUT_W   = 24;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // Odd quadrants walk the table backwards; ~idx == 1023-idx
  function automatic logic [ADDR_W-1:0] map_addr(
    input quad_t             q,
    input logic [ADDR_W-1:0] idx
  );
    logic [ADDR_W-1:0] r;
    r = idx;
    if (q == Q1 || q == Q3) r = ~idx;
    return r;
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with a one-deep pending tuning word that is swapped in
// at the phase wrap, on phase clear, or immediately while the active word is 0.
module dds_phase_acc
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] act_q, act_d;
  logic [PHASE_W-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               apply;
  logic               accept;

  always_comb begin
    sum    = {1'b0, phase_q} + {1'b0, act_q};
    carry  = sum[PHASE_W];
    accept = ftw_valid && !pend_full_q;
    apply  = pend_full_q &&
             (phase_clr || (en && (carry || act_q == '0)));

    phase_d = phase_q;
    if (phase_clr)
      phase_d = '0;
    else if (en)
      phase_d = sum[PHASE_W-1:0];

    // The apply cycle still adds with the old word
    act_d = apply ? pend_q : act_q;
    pend_d = accept ? ftw : pend_q;

    pend_full_d = pend_full_q;
    if (apply)
      pend_full_d = 1'b0;
    else if (accept)
      pend_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign ftw_ready = !pend_full_q;
  assign phase     = phase_q;

endmodule

// File: rtl/dds_quadrant_ctrl.sv
// DDS quadrant folding: phase -> quarter-wave address, sign restore on output.
// Define DDS_PHASE_DITHER_EN to add LFSR phase dithering before mapping.
module dds_quadrant_ctrl
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [LUT_W-1:0]   lut_data,
  output logic [OUT_W-1:0]   sin_out,
  output logic               sin_valid
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_m;
  quad_t              quad;
  quad_t              quad_dly_q, quad_dly_d;
  logic               vld1_q, vld1_d;
  logic               vld2_q, vld2_d;
  logic               sin_valid_q, sin_valid_d;
  logic [OUT_W-1:0]   sin_out_q, sin_out_d;
  logic [OUT_W-1:0]   mag;
  logic               unused_lsb;

  dds_phase_acc u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .phase     (phase)
  );

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (phase_clr)
      lfsr_d = LFSR_SEED;
    else if (en)
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= LFSR_SEED;
    else
      lfsr_q <= lfsr_d;
  end

  // Dither only perturbs the mapping, never the accumulator
  assign phase_m = phase + {12'h0, lfsr_q, 4'h0};
`else
  assign phase_m = phase;
`endif

  always_comb begin
    quad       = quad_t'(phase_m[PHASE_W-1 -: 2]);
    lut_addr   = map_addr(quad, phase_m[PHASE_W-3 -: ADDR_W]);
    unused_lsb = ^phase_m[PHASE_W-3-ADDR_W:0];
  end

  always_comb begin
    quad_dly_d  = quad;
    vld1_d      = en;
    vld2_d      = vld1_q;
    sin_valid_d = vld2_q;
    mag         = {1'b0, lut_data};
    sin_out_d   = sin_out_q;
    if (vld2_q)
      sin_out_d = (quad_dly_q inside {Q2, Q3}) ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad_dly_q  <= Q0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      sin_valid_q <= 1'b0;
      sin_out_q   <= '0;
    end else begin
      quad_dly_q  <= quad_dly_d;
      vld1_q      <= vld1_d;
      vld2_q      <= vld2_d;
      sin_valid_q <= sin_valid_d;
      sin_out_q   <= sin_out_d;
    end
  end

  assign sin_out   = sin_out_q;
  assign sin_valid = sin_valid_q;

endmodule

// File: tb/tb_dds_quadrant_ctrl.sv
// Directed bench for dds_quadrant_ctrl with a modelled registered
// quarter-wave table (entry 0 = 0, entry 1023 = 23'h7ffff6).
module tb_dds_quadrant_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        phase_clr;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [9:0]  lut_addr;
  logic [22:0] lut_data = '0;
  logic [23:0] sin_out;
  logic        sin_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_quadrant_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .sin_out   (sin_out),
    .sin_valid (sin_valid)
  );

  function automatic logic [22:0] lut_f(input logic [9:0] a);
    if (a == 10'd1023) return 23'h7ffff6;
    return {a, 13'd0};
  endfunction

  always @(posedge clk) lut_data <= lut_f(lut_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        clr;
    logic [9:0]  addr;
    logic [23:0] sout;
    logic        sv;
  } vec_t;

  vec_t vt[20];

  logic [11:0] pk;
  logic [9:0]  pidx, pa;
  logic [23:0] pmag, pexp;

  initial begin
    vt[0]  = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 10'd1023, 24'h000000, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 10'd1023, 24'h7ffff6, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 10'd1023, 24'h80000A, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 10'd1023, 24'h7ffff6, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 10'd1023, 24'h000000, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 10'd1023, 24'h80000A, 1'b1};
    vt[10] = '{1'b0, 1'b0, 10'd1023, 24'h80000A, 1'b0};
    vt[11] = '{1'b0, 1'b0, 10'd1023, 24'h80000A, 1'b0};
    vt[12] = '{1'b0, 1'b0, 10'd1023, 24'h80000A, 1'b0};
    vt[13] = '{1'b1, 1'b0, 10'd0,    24'h80000A, 1'b0};
    vt[14] = '{1'b1, 1'b0, 10'd1023, 24'h80000A, 1'b0};
    vt[15] = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b1};
    vt[16] = '{1'b1, 1'b0, 10'd1023, 24'h7ffff6, 1'b1};
    vt[17] = '{1'b1, 1'b0, 10'd0,    24'h000000, 1'b1};
    vt[18] = '{1'b1, 1'b1, 10'd0,    24'h80000A, 1'b1};
    vt[19] = '{1'b1, 1'b0, 10'd1023, 24'h000000, 1'b1};

    rst_n     = 1'b0;
    en        = 1'b0;
    phase_clr = 1'b0;
    ftw       = '0;
    ftw_valid = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_sin_out", sin_out, 0);
    chk("rst_sin_valid", sin_valid, 0);
    chk("rst_ftw_ready", ftw_ready, 1);
    chk("rst_lut_addr", lut_addr, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_sin_out", sin_out, 0);
    chk("idle_sin_valid", sin_valid, 0);
    chk("idle_ftw_ready", ftw_ready, 1);
    chk("idle_lut_addr", lut_addr, 0);

    // quarter-turn word, then table of continuous/stalled/cleared stream
    ftw       = 32'h4000_0000;
    ftw_valid = 1'b1;
    tick();
    chk("acc1_ready", ftw_ready, 0);
    ftw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en        = vt[i].en;
      phase_clr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_addr", i), lut_addr, vt[i].addr);
      chk($sformatf("vec%0d_sout", i), sin_out, vt[i].sout);
      chk($sformatf("vec%0d_valid", i), sin_valid, vt[i].sv);
    end
    phase_clr = 1'b0;

    // second word while pending: refused, first applies after the wrap
    en        = 1'b0;
    ftw       = 32'h1000_0000;
    ftw_valid = 1'b1;
    tick();
    chk("pend_ready0", ftw_ready, 0);
    ftw = 32'h2000_0000;
    tick();
    chk("pend_ready1", ftw_ready, 0);
    tick();
    chk("pend_ready2", ftw_ready, 0);
    ftw_valid = 1'b0;
    en        = 1'b1;
    tick();
    chk("sw_addr0", lut_addr, 0);
    chk("sw_ready0", ftw_ready, 0);
    tick();
    chk("sw_addr1", lut_addr, 1023);
    chk("sw_ready1", ftw_ready, 0);
    tick();
    chk("sw_addr2", lut_addr, 0);
    chk("sw_ready2", ftw_ready, 1);
    tick();
    chk("sw_addr3", lut_addr, 256);
    tick();
    chk("sw_addr4", lut_addr, 512);
    tick();
    chk("sw_addr5", lut_addr, 768);

    // fine word applied by phase_clr, sweep one full period
    en        = 1'b0;
    ftw       = 32'h0010_0000;
    ftw_valid = 1'b1;
    tick();
    chk("fine_ready0", ftw_ready, 0);
    ftw_valid = 1'b0;
    phase_clr = 1'b1;
    tick();
    chk("fine_clr_addr", lut_addr, 0);
    chk("fine_clr_ready", ftw_ready, 1);
    phase_clr = 1'b0;
    en        = 1'b1;
    for (int j = 1; j <= 4096; j++) begin
      tick();
      pk   = 12'(j);
      pidx = pk[9:0];
      pa   = pk[10] ? 10'(1023 - pidx) : pidx;
      chk("sweep_addr", lut_addr, pa);
      if (j >= 3) begin
        pk   = 12'(j - 2);
        pidx = pk[9:0];
        pa   = pk[10] ? 10'(1023 - pidx) : pidx;
        pmag = {1'b0, lut_f(pa)};
        pexp = pk[11] ? 24'(-pmag) : pmag;
        chk("sweep_sout", sin_out, pexp);
        chk("sweep_valid", sin_valid, 1);
      end
    end

    // async reset mid-stream with a pending word
    ftw       = 32'h0800_0000;
    ftw_valid = 1'b1;
    tick();
    chk("pre_rst_ready", ftw_ready, 0);
    ftw_valid = 1'b0;
    tick();
    chk("pre_rst_valid", sin_valid, 1);
    chk("pre_rst_addr", lut_addr, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sin_out", sin_out, 0);
    chk("arst_sin_valid", sin_valid, 0);
    chk("arst_ftw_ready", ftw_ready, 1);
    chk("arst_lut_addr", lut_addr, 0);
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", sin_valid, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_addr", lut_addr, 0);
      chk("post_rst_ready", ftw_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
